// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned Data_Bus = 32;
  localparam int unsigned Prod_W   = 2 * Data_Bus;
  localparam logic [Data_Bus-1:0] Zero_Word = '0;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } muldiv_state_t;

  // Ops that hold the pipeline until a result commits
  function automatic logic is_long_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_mul_unit.sv
// Multi-cycle multiplier: latches operands on start, counts MUL_CYCLES, flags the commit cycle.
module hilo_muldiv_ctrl_mul_unit
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                active,
  input  logic                is_signed,
  input  logic [Data_Bus-1:0] a,
  input  logic [Data_Bus-1:0] b,
  output logic                done_c,
  output logic [Prod_W-1:0]   prod_c
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0]    cnt;
  logic [Data_Bus-1:0] a_q;
  logic [Data_Bus-1:0] b_q;
  logic                sign_q;
  logic [Prod_W-1:0]   a_ext;
  logic [Prod_W-1:0]   b_ext;

  // Operand capture and cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= Zero_Word;
      b_q    <= Zero_Word;
      sign_q <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      sign_q <= is_signed;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Product of the held operands; allowed to settle over several cycles
  always_comb begin
    a_ext  = {{Data_Bus{sign_q & a_q[Data_Bus-1]}}, a_q};
    b_ext  = {{Data_Bus{sign_q & b_q[Data_Bus-1]}}, b_q};
    prod_c = a_ext * b_ext;
    done_c = active && (cnt == CNT_W'(MUL_CYCLES - 1));
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage multiply/divide control and owner of the architectural HI/LO registers.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = 2,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  muldiv_op_t          op,
  input  logic [Data_Bus-1:0] op_a,
  input  logic [Data_Bus-1:0] op_b,
  input  logic                flush,
  output logic                stall_o,
  output logic                div_start,
  output logic                div_signed,
  output logic [Data_Bus-1:0] div_src1,
  output logic [Data_Bus-1:0] div_src2,
  input  logic [Data_Bus-1:0] div_hi,
  input  logic [Data_Bus-1:0] div_lo,
  input  logic                div_finish,
  output logic [Data_Bus-1:0] hi_o,
  output logic [Data_Bus-1:0] lo_o,
  output logic                busy_o
);

  localparam int unsigned DIV_CNT_W = $clog2(DIV_TIMEOUT + 1);

  muldiv_state_t        state;
  muldiv_state_t        state_d;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 mul_start;
  logic                 mul_done_c;
  logic [Prod_W-1:0]    mul_prod_c;
  logic                 div_load;
  logic                 div_stop;
  logic                 div_timeout;
  logic                 hi_we;
  logic                 lo_we;
  logic [Data_Bus-1:0]  hi_d;
  logic [Data_Bus-1:0]  lo_d;

  hilo_muldiv_ctrl_mul_unit #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .active    (state == MUL),
    .is_signed (op == OP_MULT),
    .a         (op_a),
    .b         (op_b),
    .done_c    (mul_done_c),
    .prod_c    (mul_prod_c)
  );

  assign busy_o      = (state != IDLE);
  assign div_timeout = (state == DIV) && !div_finish &&
                       (div_cnt == DIV_CNT_W'(DIV_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, stall and HI/LO write decisions; flush overrides everything but reset
  always_comb begin
    state_d   = state;
    stall_o   = 1'b0;
    mul_start = 1'b0;
    div_load  = 1'b0;
    div_stop  = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi_o;
    lo_d      = lo_o;
    unique case (state)
      IDLE: begin
        if (op_valid && !flush) begin
          stall_o = is_long_op(op);
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_start = 1'b1;
              state_d   = MUL;
            end
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              state_d  = DIV;
            end
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_d  = op_a;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_d  = op_a;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        stall_o = !mul_done_c;
        if (mul_done_c) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_d    = mul_prod_c[Prod_W-1:Data_Bus];
          lo_d    = mul_prod_c[Data_Bus-1:0];
          state_d = IDLE;
        end
      end
      DIV: begin
        stall_o = !div_finish;
        if (div_finish) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_d     = div_hi;
          lo_d     = div_lo;
          div_stop = 1'b1;
          state_d  = IDLE;
        end else if (div_timeout) begin
          div_stop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      mul_start = 1'b0;
      div_load  = 1'b0;
      div_stop  = 1'b1;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
    end
  end

  // Architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= Zero_Word;
      lo_o <= Zero_Word;
    end else begin
      if (hi_we) hi_o <= hi_d;
      if (lo_we) lo_o <= lo_d;
    end
  end

  // Divider handshake: operands held stable while div_start is high
  always_ff @(posedge clk) begin
    if (rst) begin
      div_start  <= 1'b0;
      div_signed <= 1'b0;
      div_src1   <= Zero_Word;
      div_src2   <= Zero_Word;
    end else if (div_load) begin
      div_start  <= 1'b1;
      div_signed <= (op == OP_DIV);
      div_src1   <= op_a;
      div_src2   <= op_b;
    end else if (div_stop) begin
      div_start  <= 1'b0;
    end
  end

  // Cycles spent waiting on the divider, for the lost-finish guard
  always_ff @(posedge clk) begin
    if (rst)                div_cnt <= '0;
    else if (div_load)      div_cnt <= '0;
    else if (state == DIV)  div_cnt <= div_cnt + DIV_CNT_W'(1);
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl with a behavioural divider and HI/LO reference model.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int unsigned MUL_CYC   = 2;
  localparam int unsigned DIV_TO    = 64;
  localparam int          DIV_CYCLE = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall_o, div_start, div_signed, busy_o, div_finish;
  logic [31:0] div_src1, div_src2, div_hi, div_lo, hi_o, lo_o;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;
  logic        withhold = 1'b0;
  int          dcnt = 0;
  logic [63:0] dres;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.MUL_CYCLES(MUL_CYC), .DIV_TIMEOUT(DIV_TO)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall_o(stall_o), .div_start(div_start), .div_signed(div_signed),
    .div_src1(div_src1), .div_src2(div_src2), .div_hi(div_hi), .div_lo(div_lo),
    .div_finish(div_finish), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  // Behavioural divider: {remainder, quotient}; divide by zero returns {a, all ones}
  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin na = longint'($signed(a)); nb = longint'($signed(b)); end
    else   begin na = longint'(a);          nb = longint'(b);          end
    q = na / nb;
    r = na % nb;
    return {32'(r), 32'(q)};
  endfunction

  // External div block: finish pulses on the CYCLE+1-th cycle of permit
  always @(posedge clk) begin
    if (!div_start) dcnt <= 0;
    else            dcnt <= dcnt + 1;
  end
  assign div_finish = div_start && (dcnt == DIV_CYCLE) && !withhold;
  assign dres       = div_ref(div_signed, div_src1, div_src2);
  assign div_hi     = dres[63:32];
  assign div_lo     = dres[31:0];

  // Architectural effect of one op on HI/LO and expected stall cycles
  task automatic ref_step(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                          output int exp_stalls);
    longint      p;
    logic [63:0] d;
    exp_stalls = 0;
    case (o)
      OP_MULT:  begin p = longint'($signed(a)) * longint'($signed(b));
                      exp_hi = 32'(p >>> 32); exp_lo = 32'(p); exp_stalls = MUL_CYC; end
      OP_MULTU: begin p = longint'(a) * longint'(b);
                      exp_hi = 32'(p >> 32); exp_lo = 32'(p); exp_stalls = MUL_CYC; end
      OP_DIV:   begin d = div_ref(1'b1, a, b); exp_hi = d[63:32]; exp_lo = d[31:0];
                      exp_stalls = DIV_CYCLE + 1; end
      OP_DIVU:  begin d = div_ref(1'b0, a, b); exp_hi = d[63:32]; exp_lo = d[31:0];
                      exp_stalls = DIV_CYCLE + 1; end
      OP_MTHI:  exp_hi = a;
      OP_MTLO:  exp_lo = a;
      default:  ;
    endcase
  endtask

  // Present one op, hold it while stalled, release after the commit edge
  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int ds_hi);
    @(negedge clk);
    op_valid = 1'b1; op = o; op_a = a; op_b = b;
    #1;
    stalls = 0; ds_hi = 0;
    while (stall_o === 1'b1 && stalls < 200) begin
      stalls++;
      if (div_start === 1'b1) ds_hi++;
      @(negedge clk); #1;
    end
    if (div_start === 1'b1) ds_hi++;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op = OP_NONE; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0)
      $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi_o, lo_o); else passes++;
    checks++; if (busy_o !== 1'b0 || stall_o !== 1'b0 || div_start !== 1'b0)
      $display("FAIL reset_ctrl busy=%b stall=%b div_start=%b want 0", busy_o, stall_o, div_start); else passes++;
    checks++; if (div_src1 !== 32'h0 || div_src2 !== 32'h0 || div_signed !== 1'b0)
      $display("FAIL reset_divregs src1=%h src2=%h sgn=%b want 0", div_src1, div_src2, div_signed); else passes++;
  endtask

  task automatic test_mult();
    int st, ds, es;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, st, ds);
    ref_step(OP_MULT, 32'hFFFF_FFFF, 32'h2, es);
    checks++; if (st !== 2) $display("FAIL mult_stall got=%0d want=2", st); else passes++;
    checks++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE)
      $display("FAIL mult_result hi=%h lo=%h want ffffffff/fffffffe", hi_o, lo_o); else passes++;
  endtask

  task automatic test_multu();
    int st, ds, es;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, ds);
    ref_step(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, es);
    checks++; if (st !== 2) $display("FAIL multu_stall got=%0d want=2", st); else passes++;
    checks++; if (hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h0000_0001)
      $display("FAIL multu_result hi=%h lo=%h want fffffffe/00000001", hi_o, lo_o); else passes++;
  endtask

  task automatic test_div();
    int st, ds, es;
    run_op(OP_DIV, 32'h7, 32'hFFFF_FFFE, st, ds);
    ref_step(OP_DIV, 32'h7, 32'hFFFF_FFFE, es);
    checks++; if (st !== 11) $display("FAIL div_stall got=%0d want=11", st); else passes++;
    checks++; if (ds !== 11) $display("FAIL div_start_len got=%0d want=11", ds); else passes++;
    checks++; if (div_start !== 1'b0) $display("FAIL div_start_drop got=%b want=0", div_start); else passes++;
    checks++; if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFD)
      $display("FAIL div_result hi=%h lo=%h want 00000001/fffffffd", hi_o, lo_o); else passes++;
  endtask

  task automatic test_back_to_back();
    int st, ds, es;
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h2, st, ds);
    ref_step(OP_DIVU, 32'hFFFF_FFFF, 32'h2, es);
    checks++; if (hi_o !== 32'h1 || lo_o !== 32'h7FFF_FFFF)
      $display("FAIL divu_result hi=%h lo=%h want 00000001/7fffffff", hi_o, lo_o); else passes++;
    run_op(OP_MTHI, 32'h1234_5678, 32'h0, st, ds);
    ref_step(OP_MTHI, 32'h1234_5678, 32'h0, es);
    checks++; if (st !== 0) $display("FAIL mthi_stall got=%0d want=0", st); else passes++;
    checks++; if (hi_o !== 32'h1234_5678 || lo_o !== 32'h7FFF_FFFF)
      $display("FAIL mthi_result hi=%h lo=%h want 12345678/7fffffff", hi_o, lo_o); else passes++;
  endtask

  task automatic preload_a5();
    int st, ds, es;
    run_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0, st, ds); ref_step(OP_MTHI, 32'hA5A5_A5A5, 32'h0, es);
    run_op(OP_MTLO, 32'hA5A5_A5A5, 32'h0, st, ds); ref_step(OP_MTLO, 32'hA5A5_A5A5, 32'h0, es);
    checks++; if (hi_o !== 32'hA5A5_A5A5 || lo_o !== 32'hA5A5_A5A5)
      $display("FAIL mt_preload hi=%h lo=%h want a5a5a5a5", hi_o, lo_o); else passes++;
  endtask

  task automatic test_flush();
    logic was_started;
    preload_a5();
    @(negedge clk); op_valid = 1'b1; op = OP_DIV; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    repeat (4) @(negedge clk);
    was_started = div_start;
    flush = 1'b1; op_valid = 1'b0; op = OP_NONE;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (was_started !== 1'b1) $display("FAIL flush_pre_start got=%b want=1", was_started); else passes++;
    checks++; if (busy_o !== 1'b0 || div_start !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL flush_ctrl busy=%b div_start=%b stall=%b want 0", busy_o, div_start, stall_o); else passes++;
    checks++; if (hi_o !== exp_hi || lo_o !== exp_lo)
      $display("FAIL flush_hilo hi=%h lo=%h want %h/%h", hi_o, lo_o, exp_hi, exp_lo); else passes++;
  endtask

  task automatic test_flush_commit();
    int n;
    @(negedge clk); op_valid = 1'b1; op = OP_DIVU; op_a = 32'd55; op_b = 32'd5; #1;
    n = 0;
    while (div_finish !== 1'b1 && n < 50) begin n++; @(negedge clk); #1; end
    checks++; if (div_finish !== 1'b1) $display("FAIL flushc_finish_seen got=%b want=1", div_finish); else passes++;
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; op_valid = 1'b0; op = OP_NONE;
    checks++; if (hi_o !== exp_hi || lo_o !== exp_lo)
      $display("FAIL flushc_hilo hi=%h lo=%h want %h/%h", hi_o, lo_o, exp_hi, exp_lo); else passes++;
    checks++; if (busy_o !== 1'b0 || div_start !== 1'b0)
      $display("FAIL flushc_ctrl busy=%b div_start=%b want 0", busy_o, div_start); else passes++;
  endtask

  task automatic test_flush_mt();
    @(negedge clk); op_valid = 1'b1; op = OP_MTLO; op_a = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; op_valid = 1'b0; op = OP_NONE;
    checks++; if (lo_o !== exp_lo) $display("FAIL flush_mtlo lo=%h want %h", lo_o, exp_lo); else passes++;
  endtask

  task automatic test_timeout();
    int n;
    withhold = 1'b1;
    @(negedge clk); op_valid = 1'b1; op = OP_DIV; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk); #1; op_valid = 1'b0; op = OP_NONE;
    n = 0;
    while (busy_o === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    withhold = 1'b0;
    checks++; if (n !== 64) $display("FAIL timeout_len got=%0d want=64", n); else passes++;
    checks++; if (hi_o !== exp_hi || lo_o !== exp_lo || div_start !== 1'b0)
      $display("FAIL timeout_state hi=%h lo=%h ds=%b want %h/%h/0", hi_o, lo_o, div_start, exp_hi, exp_lo); else passes++;
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk); op_valid = 1'b1; op = OP_MULTU; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0; op = OP_NONE; flush = 1'b1;
    @(posedge clk); #1; rst = 1'b0; flush = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0)
      $display("FAIL rstmul_hilo hi=%h lo=%h want 0/0", hi_o, lo_o); else passes++;
    checks++; if (stall_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL rstmul_ctrl stall=%b busy=%b want 0/0", stall_o, busy_o); else passes++;
  endtask

  task automatic test_random();
    muldiv_op_t  o;
    logic [31:0] a, b;
    int          st, ds, es;
    for (int i = 0; i < 30; i++) begin
      o = muldiv_op_t'($urandom_range(0, 6));
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
      run_op(o, a, b, st, ds);
      ref_step(o, a, b, es);
      checks++; if (st !== es) $display("FAIL rand%0d_stall op=%0d got=%0d want=%0d", i, o, st, es); else passes++;
      checks++; if (hi_o !== exp_hi || lo_o !== exp_lo)
        $display("FAIL rand%0d_hilo op=%0d a=%h b=%h hi=%h lo=%h want %h/%h", i, o, a, b, hi_o, lo_o, exp_hi, exp_lo);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_back_to_back();
    test_flush();
    test_flush_commit();
    test_flush_mt();
    test_timeout();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Execute-stage control for multiply/divide and owner of the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage. Divides are issued to the `div` block by driving its permit/sign/operand inputs and consuming its hi/lo/finish outputs. Multiplies run on an internal multi-cycle multiplier. The block stalls the pipeline until the result commits.

Parameters:
MUL_CYCLES, 2, cycles from multiply acceptance to commit (range 1..15)
DIV_TIMEOUT, 64, cycles in DIV before forced abort; guards against a lost finish

Ports:
clk            input   1   system clock
rst            input   1   synchronous reset, active-high
op_valid       input   1   EX-stage instruction valid
op             input   3   muldiv_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
op_a           input   32  rs value
op_b           input   32  rt value
flush          input   1   exception/eret flush; cancels any in-flight operation
stall_o        output  1   hold EX and upstream stages
div_start      output  1   to div permit_div; registered
div_signed     output  1   to div mult_sign; registered
div_src1       output  32  dividend; registered, stable while div_start=1
div_src2       output  32  divisor; registered, stable while div_start=1
div_hi         input   32  remainder from div
div_lo         input   32  quotient from div
div_finish     input   1   finish_div from div; one-cycle pulse
hi_o           output  32  current HI register
lo_o           output  32  current LO register
busy_o         output  1   state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - state=IDLE; hi_o, lo_o = 0.
  - div_start, div_signed, div_src1, div_src2 = 0; counters = 0.
- A long op is MULT, MULTU, DIV or DIVU. stall_o = (state==IDLE & op_valid & long op & !flush) | (state!=IDLE & !commit).
- IDLE:
  - MTHI: HI<=op_a at the edge, no stall. MTLO: LO<=op_a.
  - MULT/MULTU: latch op_a, op_b and the sign flag; load counter=0; go to MUL.
  - DIV/DIVU: div_src1<=op_a, div_src2<=op_b, div_signed<=(op==DIV), div_start<=1; go to DIV.
  - op_valid=0 or op=NONE: stay in IDLE.
- MUL:
  - Counter increments each cycle. Product is a 64-bit signed or unsigned product of the latched operands, and may be a multicycle path.
  - Commit cycle is when counter==MUL_CYCLES-1, i.e. MUL_CYCLES cycles after acceptance. In it: stall_o=0, HI<=prod[63:32], LO<=prod[31:0], next state IDLE.
- DIV:
  - div_start stays high and the operands are held constant.
  - Commit is div_finish=1. In that cycle: stall_o=0, HI<=div_hi, LO<=div_lo, div_start<=0, next state IDLE.
  - div_start must drop the cycle after finish; otherwise `div` restarts its counter.
  - Latency with div CYCLE=10: acceptance at T, div_start high T+1..T+11, commit at T+11, 11 stall cycles.
- Timeout: if the DIV cycle count reaches DIV_TIMEOUT without finish, go to IDLE with div_start<=0 and no HI/LO write.
- Divide by zero: no exception; HI/LO take whatever div returns.
- The held instruction is still presented during the commit cycle. It is not re-accepted, because the state is non-IDLE there.
- flush=1, in any state:
  - next state IDLE, div_start<=0, no HI/LO write, even if commit coincides.
  - A long op presented with flush is not accepted.
  - MTHI/MTLO with flush does not write.
- hi_o/lo_o are register outputs. A read in the cycle after commit sees the new value; no bypass is provided.
- Simultaneous rst and flush: reset wins.

Decomposition:
- Shared package:
  - muldiv_op_t enum (3 bits)
  - muldiv_state_t {IDLE, MUL, DIV}
  - Data_Bus=32
  - Zero_Word
- One sub-module, mul_unit. It holds the operand registers, the signed/unsigned 64-bit product and the MUL_CYCLES counter, and raises a done pulse. The divider stays external, in `div`.

Test Plan:
1. MULT: op_a=0xFFFFFFFF, op_b=2 -> stall_o high 2 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. MULTU: op_a=op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. DIV with a `div` model at CYCLE=10:
   - op_a=7, op_b=0xFFFFFFFE (-2) -> div_start high 11 cycles, stall_o 11 cycles.
   - Result HI=1, LO=0xFFFFFFFD.
   - div_start=0 the cycle after finish.
4. DIVU: op_a=0xFFFFFFFF, op_b=2 -> HI=1, LO=0x7FFFFFFF.
   - Immediately followed by MTHI op_a=0x12345678 -> HI=0x12345678, LO unchanged, no stall.
5. Flush:
   - Flush 4 cycles into a DIV with prior HI=LO=0xA5A5A5A5 -> next cycle IDLE, div_start=0, HI/LO unchanged.
   - Flush coincident with a DIV commit also leaves HI/LO unchanged.
6. Reset and timeout:
   - rst asserted mid-MUL -> next cycle hi_o=lo_o=0, stall_o=0, busy_o=0.
   - Withheld div_finish -> abort after 64 cycles, HI/LO unchanged.
